// File: rtl/ins_fetch_sequencer.sv
// Fetch-stage sequencer: launches a program at a start PC and drives freeze / pc_choice /
// wait_for_next from the fetch unit's comm word. Optional dependency watchdog: FETCH_SEQ_DEP_TIMEOUT_EN.
module ins_fetch_sequencer #(
    parameter int PC_WIDTH           = 32,
    parameter int DEP_ID_WIDTH       = 16,
    parameter int STALL_CNT_WIDTH    = 32,
    parameter int DEP_TIMEOUT_CYCLES = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start_in,
    input  logic [PC_WIDTH-1:0]        start_pc_in,
    input  logic                       resume_in,
    input  logic                       comm_enable_in,
    input  logic [DEP_ID_WIDTH+2:0]    comm_signal_in,
    input  logic                       dep_done_valid_in,
    input  logic [DEP_ID_WIDTH-1:0]    dep_done_id_in,
    output logic [PC_WIDTH-1:0]        pc_init_out,
    output logic                       pc_choice_out,
    output logic                       freeze_out,
    output logic                       wait_for_next_out,
    output logic                       busy_out,
    output logic                       done_out,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles_out
`ifdef FETCH_SEQ_DEP_TIMEOUT_EN
    ,
    output logic                       timeout_err_out
`endif
);

    localparam int CW = DEP_ID_WIDTH + 3;

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_DEP_WAIT, S_STOPPED, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [1:0]              code;
    logic                    dep_flag;
    logic [DEP_ID_WIDTH-1:0] comm_id;
    logic                    c_start, c_stop, c_end;
    logic                    dep_match, accept_start, timeout_hit;

    logic [PC_WIDTH-1:0]        pc_init_q, pc_init_d;
    logic [DEP_ID_WIDTH-1:0]    dep_id_q, dep_id_d;
    logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
    logic freeze_q, freeze_d, choice_q, choice_d, wfn_q, wfn_d;
    logic busy_q, busy_d, done_q, done_d;

    assign code     = comm_signal_in[CW-1:CW-2];
    assign dep_flag = comm_signal_in[DEP_ID_WIDTH];
    assign comm_id  = comm_signal_in[DEP_ID_WIDTH-1:0];

    // Code 01 is reserved and decodes to nothing
    assign c_start = comm_enable_in && (code == 2'b10);
    assign c_stop  = comm_enable_in && (code == 2'b11);
    assign c_end   = comm_enable_in && (code == 2'b00);

    assign dep_match    = dep_done_valid_in && (dep_done_id_in == dep_id_q);
    assign accept_start = start_in && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef FETCH_SEQ_DEP_TIMEOUT_EN
    localparam int WD_W = $clog2(DEP_TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            terr_q, terr_d;

    // Held at zero outside DEP_WAIT, so every entry starts a fresh count
    assign wd_d        = (state_q == S_DEP_WAIT) ? wd_q + 1'b1 : '0;
    assign timeout_hit = (state_q == S_DEP_WAIT) && (wd_q == WD_W'(DEP_TIMEOUT_CYCLES - 1));

    always_comb begin
        terr_d = terr_q;
        if (accept_start)
            terr_d = 1'b0;
        else if (timeout_hit && !c_end && !dep_match)
            terr_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_q   <= '0;
            terr_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err_out = terr_q;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start_in) state_d = S_LAUNCH;
            S_LAUNCH:   state_d = S_RUN;
            S_RUN: begin
                if (c_start && dep_flag) state_d = S_DEP_WAIT;
                else if (c_stop)         state_d = S_STOPPED;
                else if (c_end)          state_d = S_DONE;
            end
            S_DEP_WAIT: begin
                if (c_end)            state_d = S_DONE;
                else if (dep_match)   state_d = S_RUN;
                else if (timeout_hit) state_d = S_DONE;
            end
            S_STOPPED: begin
                if (c_end)          state_d = S_DONE;
                else if (resume_in) state_d = S_RUN;
            end
            S_DONE:     if (start_in) state_d = S_LAUNCH;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they move with the state
    always_comb begin
        freeze_d = 1'b1;
        choice_d = 1'b0;
        wfn_d    = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_d)
            S_IDLE:     choice_d = 1'b1;
            S_LAUNCH: begin
                choice_d = 1'b1;
                freeze_d = 1'b0;
                busy_d   = 1'b1;
            end
            S_RUN: begin
                freeze_d = 1'b0;
                busy_d   = 1'b1;
            end
            S_DEP_WAIT: begin
                wfn_d  = 1'b1;
                busy_d = 1'b1;
            end
            S_STOPPED:  busy_d = 1'b1;
            S_DONE: begin
                wfn_d  = 1'b1;
                done_d = 1'b1;
            end
            default:    choice_d = 1'b1;
        endcase

        pc_init_d = accept_start ? start_pc_in : pc_init_q;
        dep_id_d  = ((state_q == S_RUN) && (state_d == S_DEP_WAIT)) ? comm_id : dep_id_q;

        stall_d = stall_q;
        if (accept_start)
            stall_d = '0;
        else if ((state_q == S_DEP_WAIT) && (stall_q != '1))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_init_q <= '0;
            dep_id_q  <= '0;
            stall_q   <= '0;
            freeze_q  <= 1'b1;
            choice_q  <= 1'b1;
            wfn_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            pc_init_q <= pc_init_d;
            dep_id_q  <= dep_id_d;
            stall_q   <= stall_d;
            freeze_q  <= freeze_d;
            choice_q  <= choice_d;
            wfn_q     <= wfn_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign pc_init_out       = pc_init_q;
    assign pc_choice_out     = choice_q;
    assign freeze_out        = freeze_q;
    assign wait_for_next_out = wfn_q;
    assign busy_out          = busy_q;
    assign done_out          = done_q;
    assign stall_cycles_out  = stall_q;

endmodule

// File: tb/tb_ins_fetch_sequencer.sv
// Directed bench for ins_fetch_sequencer; covers launch, dependency wait, stop/resume,
// priorities, async reset and (with FETCH_SEQ_DEP_TIMEOUT_EN) the dependency watchdog.
module tb_ins_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_in = 1'b0;
    logic [31:0] start_pc_in = '0;
    logic        resume_in = 1'b0;
    logic        comm_enable_in = 1'b0;
    logic [18:0] comm_signal_in = '0;
    logic        dep_done_valid_in = 1'b0;
    logic [15:0] dep_done_id_in = '0;
    logic [31:0] pc_init_out;
    logic        pc_choice_out, freeze_out, wait_for_next_out, busy_out, done_out;
    logic [31:0] stall_cycles_out;
`ifdef FETCH_SEQ_DEP_TIMEOUT_EN
    logic        timeout_err_out;
`endif

    int checks = 0;
    int errors = 0;

    ins_fetch_sequencer #(
        .PC_WIDTH(32), .DEP_ID_WIDTH(16), .STALL_CNT_WIDTH(32), .DEP_TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start_in(start_in),
        .start_pc_in(start_pc_in),
        .resume_in(resume_in),
        .comm_enable_in(comm_enable_in),
        .comm_signal_in(comm_signal_in),
        .dep_done_valid_in(dep_done_valid_in),
        .dep_done_id_in(dep_done_id_in),
        .pc_init_out(pc_init_out),
        .pc_choice_out(pc_choice_out),
        .freeze_out(freeze_out),
        .wait_for_next_out(wait_for_next_out),
        .busy_out(busy_out),
        .done_out(done_out),
        .stall_cycles_out(stall_cycles_out)
`ifdef FETCH_SEQ_DEP_TIMEOUT_EN
        ,
        .timeout_err_out(timeout_err_out)
`endif
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic comm(input logic [1:0] code, input logic dep, input logic [15:0] id);
        comm_enable_in = 1'b1;
        comm_signal_in = {code, dep, id};
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_freeze"}, 64'(freeze_out), 64'd1);
        check({tag, "_choice"}, 64'(pc_choice_out), 64'd1);
        check({tag, "_wfn"}, 64'(wait_for_next_out), 64'd0);
        check({tag, "_pcinit"}, 64'(pc_init_out), 64'd0);
        check({tag, "_busy"}, 64'(busy_out), 64'd0);
        check({tag, "_done"}, 64'(done_out), 64'd0);
        check({tag, "_stall"}, 64'(stall_cycles_out), 64'd0);
`ifdef FETCH_SEQ_DEP_TIMEOUT_EN
        check({tag, "_terr"}, 64'(timeout_err_out), 64'd0);
`endif
    endtask

    initial begin
        step();
        step();
        check_reset_outputs("rst");
        reset = 1'b0;

        // Launch
        start_in = 1'b1; start_pc_in = 32'h0000_0040;
        step();
        start_in = 1'b0;
        check("launch_choice", 64'(pc_choice_out), 64'd1);
        check("launch_pcinit", 64'(pc_init_out), 64'h40);
        check("launch_freeze", 64'(freeze_out), 64'd0);
        check("launch_busy", 64'(busy_out), 64'd1);
        step();
        check("run_choice", 64'(pc_choice_out), 64'd0);
        check("run_busy", 64'(busy_out), 64'd1);
        check("run_freeze", 64'(freeze_out), 64'd0);

        // start_in ignored while running
        start_in = 1'b1; start_pc_in = 32'h0000_0099;
        step();
        start_in = 1'b0;
        check("run_start_pc", 64'(pc_init_out), 64'h40);
        check("run_start_choice", 64'(pc_choice_out), 64'd0);

        // Dependency wait, mismatched id then match on 5th cycle
        comm(2'b10, 1'b1, 16'h00A5);
        step();
        comm_enable_in = 1'b0;
        check("dep_wfn", 64'(wait_for_next_out), 64'd1);
        check("dep_freeze", 64'(freeze_out), 64'd1);
        dep_done_valid_in = 1'b1; dep_done_id_in = 16'h0011;
        step();
        dep_done_valid_in = 1'b0;
        check("dep_mismatch_wfn", 64'(wait_for_next_out), 64'd1);
        step();
        step();
        step();
        check("dep_stall4", 64'(stall_cycles_out), 64'd4);
        dep_done_valid_in = 1'b1; dep_done_id_in = 16'h00A5;
        step();
        dep_done_valid_in = 1'b0;
        check("dep_release_wfn", 64'(wait_for_next_out), 64'd0);
        check("dep_release_freeze", 64'(freeze_out), 64'd0);
        check("dep_stall5", 64'(stall_cycles_out), 64'd5);

        // Stop / resume
        comm(2'b11, 1'b0, 16'h0000);
        step();
        comm_enable_in = 1'b0;
        check("stop_freeze", 64'(freeze_out), 64'd1);
        check("stop_busy", 64'(busy_out), 64'd1);
        step();
        step();
        check("stop_hold_freeze", 64'(freeze_out), 64'd1);
        resume_in = 1'b1;
        step();
        resume_in = 1'b0;
        check("resume_freeze", 64'(freeze_out), 64'd0);

        // End of program
        comm(2'b00, 1'b0, 16'h0000);
        step();
        comm_enable_in = 1'b0;
        check("end_done", 64'(done_out), 64'd1);
        check("end_wfn", 64'(wait_for_next_out), 64'd1);
        check("end_busy", 64'(busy_out), 64'd0);
        check("end_stall", 64'(stall_cycles_out), 64'd5);

        // Restart from DONE
        start_in = 1'b1; start_pc_in = 32'h0000_0080;
        step();
        start_in = 1'b0;
        check("restart_choice", 64'(pc_choice_out), 64'd1);
        check("restart_pcinit", 64'(pc_init_out), 64'h80);
        check("restart_stall", 64'(stall_cycles_out), 64'd0);
        check("restart_done", 64'(done_out), 64'd0);
        step();

        // Reserved code and start without dependency leave RUN untouched
        comm(2'b01, 1'b1, 16'h0033);
        step();
        check("rsvd_freeze", 64'(freeze_out), 64'd0);
        check("rsvd_wfn", 64'(wait_for_next_out), 64'd0);
        comm(2'b10, 1'b0, 16'h0033);
        step();
        comm_enable_in = 1'b0;
        check("nodep_wfn", 64'(wait_for_next_out), 64'd0);
        check("nodep_busy", 64'(busy_out), 64'd1);

        // End wins over a matching dep_done in DEP_WAIT
        comm(2'b10, 1'b1, 16'h0033);
        step();
        comm(2'b00, 1'b0, 16'h0000);
        dep_done_valid_in = 1'b1; dep_done_id_in = 16'h0033;
        step();
        comm_enable_in = 1'b0; dep_done_valid_in = 1'b0;
        check("prio_dep_done", 64'(done_out), 64'd1);
        check("prio_dep_stall", 64'(stall_cycles_out), 64'd1);

        // End wins over resume in STOPPED
        start_in = 1'b1; start_pc_in = 32'h0000_0100;
        step();
        start_in = 1'b0;
        step();
        comm(2'b11, 1'b0, 16'h0000);
        step();
        comm(2'b00, 1'b0, 16'h0000);
        resume_in = 1'b1;
        step();
        comm_enable_in = 1'b0; resume_in = 1'b0;
        check("prio_stop_done", 64'(done_out), 64'd1);
        check("prio_stop_freeze", 64'(freeze_out), 64'd1);

        // Asynchronous reset mid-DEP_WAIT
        start_in = 1'b1; start_pc_in = 32'h0000_0200;
        step();
        start_in = 1'b0;
        step();
        comm(2'b10, 1'b1, 16'h0005);
        step();
        comm_enable_in = 1'b0;
        step();
        check("pre_areset_wfn", 64'(wait_for_next_out), 64'd1);
        #3 reset = 1'b1;
        #1;
        check_reset_outputs("areset");
        step();
        reset = 1'b0;

`ifdef FETCH_SEQ_DEP_TIMEOUT_EN
        // Watchdog: DONE with timeout_err on the 8th DEP_WAIT cycle
        start_in = 1'b1; start_pc_in = 32'h0000_0300;
        step();
        start_in = 1'b0;
        step();
        comm(2'b10, 1'b1, 16'h0077);
        step();
        comm_enable_in = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("wd_pre_done", 64'(done_out), 64'd0);
        check("wd_pre_terr", 64'(timeout_err_out), 64'd0);
        step();
        check("wd_done", 64'(done_out), 64'd1);
        check("wd_terr", 64'(timeout_err_out), 64'd1);
        check("wd_stall", 64'(stall_cycles_out), 64'd8);
        step();
        check("wd_terr_sticky", 64'(timeout_err_out), 64'd1);
        start_in = 1'b1; start_pc_in = 32'h0000_0400;
        step();
        start_in = 1'b0;
        check("wd_terr_clear", 64'(timeout_err_out), 64'd0);
        check("wd_restart_pc", 64'(pc_init_out), 64'h400);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
